scored_board: RTL and testbench
===============================

SCORED_BOARD -- requirements
Module: scored_board

Interface
REQ-001 SHALL have parameter WORD_LEN, default 5, letters per word.
REQ-002 SHALL have parameter NUM_WORDS, default 7, board rows; row 0 holds the solution.
REQ-003 SHALL have parameter LETTER_W, default 5, letter code width; code 0 means blank.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-006 SHALL have port clear, input, 1, synchronous clear of all board letters to 0.
REQ-007 SHALL have port word_mask, input, NUM_WORDS, one-hot-or-multi row write select.
REQ-008 SHALL have port letter_mask, input, WORD_LEN, column write select.
REQ-009 SHALL have port new_letter, input, LETTER_W, write data.
REQ-010 SHALL have ports word_index and letter_index, input, clog2(NUM_WORDS) and clog2(WORD_LEN), read address.
REQ-011 SHALL have port letter, output, LETTER_W, registered read data.
REQ-012 SHALL have ports score_req and score_row, input, 1 and clog2(NUM_WORDS), scoring request and guess row.
REQ-013 SHALL have ports score_busy and score_valid, output, 1 each.
REQ-014 SHALL have port colors, output, 2*WORD_LEN; 2 bits per position: 0 blank, 1 grey, 2 yellow, 3 green.

Function
REQ-015 SHALL write new_letter into every cell with word_mask[r] and letter_mask[c] both set, one cycle.
REQ-016 SHALL give clear priority over a same-cycle write.
REQ-017 SHALL present board[word_index][letter_index] on letter one cycle after the address; out-of-range addresses read 0.
REQ-018 SHALL run the FSM IDLE -> GREEN -> YELLOW -> DONE -> IDLE.
REQ-019 SHALL accept score_req only in IDLE; requests while score_busy=1 are dropped.
REQ-020 SHALL, on acceptance, snapshot the guess row and row 0; later board writes or clears do not affect that scoring.
REQ-021 GREEN (1 cycle) SHALL mark position i green where guess[i]==sol[i] and guess[i]!=0, and SHALL mark sol[i] used.
REQ-022 YELLOW SHALL last exactly WORD_LEN cycles, visiting guess position i=0..WORD_LEN-1 in order.
REQ-023 In YELLOW, for a non-green, non-blank guess[i], SHALL select the lowest unused j with sol[j]==guess[i], mark it used, and score yellow; with no such j, score grey.
REQ-024 SHALL score blank guess letters 0 and never let them consume solution letters.
REQ-025 DONE SHALL raise score_valid for exactly one cycle.
REQ-026 SHALL hold colors from that valid cycle until the next accepted request.
REQ-027 SHALL keep score_busy=1 from the cycle after acceptance through the DONE cycle.
REQ-028 SHALL make score_valid rise WORD_LEN+2 cycles after the accepting edge.
REQ-029 SHALL score a request with score_row=0 normally (all green for a non-blank solution).
REQ-030 SHALL treat score_row>=NUM_WORDS as an all-blank guess.

Reset
REQ-031 On rst SHALL clear all board cells to 0, FSM to IDLE, letter=0, colors=0, score_busy=0, score_valid=0, used flags to 0.
REQ-032 rst mid-scoring SHALL abort the scoring with no score_valid pulse.
REQ-033 After rst deassertion SHALL accept a request on the first clock.

Structure
REQ-034 The shared package asicle_pkg SHALL hold the color typedef (BLANK/GREY/YELLOW/GREEN) and the FSM state typedef.
REQ-035 Scoring (snapshot, FSM, used flags) SHALL be in sub-module word_scorer; storage and read port stay in scored_board.

Verification
REQ-036 Test: sol CRANE, guess CRANE -> colors all green, valid at accept+7 (defaults).
REQ-037 Test: sol ABBEY, guess BABES -> Y,Y,G,G,grey.
REQ-038 Test: sol CRANE, guess EERIE -> grey,grey,Y,grey,G (duplicate E consumed once).
REQ-039 Test: write row 0 mid-scoring, re-request during busy -> first result is unchanged and the dropped request produces no second valid.
REQ-040 Test: rst asserted 3 cycles after accept -> no valid, colors=0, board reads 0.
REQ-041 Test: guess with blanks at positions 1,3 -> those colors 0, others scored normally.

Source files
------------

// File: rtl/asicle_pkg.sv
// Shared types for the word board: per-letter score colours and the scorer FSM states.
package asicle_pkg;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    GREY   = 2'd1,
    YELLOW = 2'd2,
    GREEN  = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GREEN,
    ST_YELLOW,
    ST_DONE
  } state_t;

  // Index width that stays legal for a single-entry dimension.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scored_board_if.sv
// Board write/read and scoring handshake bundle shared by the board and its driver.
interface scored_board_if
  import asicle_pkg::*;
#(
  parameter int WORD_LEN  = 5,
  parameter int NUM_WORDS = 7,
  parameter int LETTER_W  = 5
);
  localparam int WI = idx_w(NUM_WORDS);
  localparam int LI = idx_w(WORD_LEN);

  logic                  clear;
  logic [NUM_WORDS-1:0]  word_mask;
  logic [WORD_LEN-1:0]   letter_mask;
  logic [LETTER_W-1:0]   new_letter;
  logic [WI-1:0]         word_index;
  logic [LI-1:0]         letter_index;
  logic [LETTER_W-1:0]   letter;
  logic                  score_req;
  logic [WI-1:0]         score_row;
  logic                  score_busy;
  logic                  score_valid;
  logic [2*WORD_LEN-1:0] colors;

  modport master (
    output clear, word_mask, letter_mask, new_letter, word_index, letter_index,
           score_req, score_row,
    input  letter, score_busy, score_valid, colors
  );

  modport slave (
    input  clear, word_mask, letter_mask, new_letter, word_index, letter_index,
           score_req, score_row,
    output letter, score_busy, score_valid, colors
  );
endinterface

// File: rtl/word_scorer.sv
// Scores a snapshotted guess against a snapshotted solution: one green pass, then one
// yellow/grey decision per position so duplicate letters consume solution letters in order.
module word_scorer
  import asicle_pkg::*;
#(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req,
  input  logic [WORD_LEN-1:0][LETTER_W-1:0]   guess_word,
  input  logic [WORD_LEN-1:0][LETTER_W-1:0]   sol_word,
  output logic                                busy,
  output logic                                valid,
  output logic [2*WORD_LEN-1:0]               colors
);
  localparam int IW = idx_w(WORD_LEN);

  state_t                              state;
  logic [WORD_LEN-1:0][LETTER_W-1:0]   guess, sol;
  logic [WORD_LEN-1:0]                 used, eq;
  logic [WORD_LEN-1:0][1:0]            col_w;
  logic [IW-1:0]                       idx, hit_j;
  logic [LETTER_W-1:0]                 cur;
  logic                                hit;

  // Blank guess letters never match, so they can never claim a solution letter.
  always_comb begin
    eq = '0;
    for (int i = 0; i < WORD_LEN; i++)
      eq[i] = (guess[i] == sol[i]) && (guess[i] != '0);
  end

  // Lowest unused solution position holding the current guess letter.
  always_comb begin
    cur   = guess[idx];
    hit   = 1'b0;
    hit_j = '0;
    for (int j = WORD_LEN - 1; j >= 0; j--) begin
      if (!used[j] && (sol[j] == cur)) begin
        hit   = 1'b1;
        hit_j = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      guess  <= '0;
      sol    <= '0;
      used   <= '0;
      col_w  <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      colors <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            guess <= guess_word;
            sol   <= sol_word;
            used  <= '0;
            col_w <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_GREEN;
          end
        end
        ST_GREEN: begin
          for (int i = 0; i < WORD_LEN; i++)
            if (eq[i]) col_w[i] <= GREEN;
          used  <= eq;
          state <= ST_YELLOW;
        end
        ST_YELLOW: begin
          if (!eq[idx] && (cur != '0)) begin
            if (hit) begin
              used[hit_j] <= 1'b1;
              col_w[idx]  <= YELLOW;
            end else begin
              col_w[idx]  <= GREY;
            end
          end
          if (idx == IW'(WORD_LEN - 1)) state <= ST_DONE;
          else                          idx   <= idx + 1'b1;
        end
        ST_DONE: begin
          valid  <= 1'b1;
          colors <= col_w;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/scored_board.sv
// Letter board with masked multi-cell writes, a registered read port, and a scorer
// that grades any row against row 0.
module scored_board
  import asicle_pkg::*;
#(
  parameter int WORD_LEN  = 5,
  parameter int NUM_WORDS = 7,
  parameter int LETTER_W  = 5
) (
  input  logic           clk,
  input  logic           rst,
  scored_board_if.slave  bus
);
  typedef logic [WORD_LEN-1:0][LETTER_W-1:0] word_t;

  word_t [NUM_WORDS-1:0]  board;
  word_t                  guess_word;
  logic                   rd_ok, row_ok;
  logic                   busy_w, valid_w;
  logic [2*WORD_LEN-1:0]  colors_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board <= '0;
    end else if (bus.clear) begin
      board <= '0;
    end else begin
      for (int r = 0; r < NUM_WORDS; r++)
        for (int c = 0; c < WORD_LEN; c++)
          if (bus.word_mask[r] && bus.letter_mask[c]) board[r][c] <= bus.new_letter;
    end
  end

  always_comb begin
    rd_ok  = (int'(bus.word_index) < NUM_WORDS) && (int'(bus.letter_index) < WORD_LEN);
    row_ok = int'(bus.score_row) < NUM_WORDS;
    // A row past the board end grades as an all-blank guess.
    guess_word = row_ok ? board[bus.score_row] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        bus.letter <= '0;
    else if (rd_ok) bus.letter <= board[bus.word_index][bus.letter_index];
    else            bus.letter <= '0;
  end

  word_scorer #(
    .WORD_LEN (WORD_LEN),
    .LETTER_W (LETTER_W)
  ) u_scorer (
    .clk        (clk),
    .rst        (rst),
    .req        (bus.score_req),
    .guess_word (guess_word),
    .sol_word   (board[0]),
    .busy       (busy_w),
    .valid      (valid_w),
    .colors     (colors_w)
  );

  assign bus.score_busy  = busy_w;
  assign bus.score_valid = valid_w;
  assign bus.colors      = colors_w;

endmodule

// File: tb/tb_scored_board.sv
// Directed bench: stimulus pushes hand-computed colour results, a negedge monitor pops
// them whenever score_valid is seen and checks both colours and latency.
module tb_scored_board;
  import asicle_pkg::*;

  localparam int WL = 5, NW = 7, LW = 5;
  localparam logic [4:0] LA = 5'd1,  LB = 5'd2,  LC = 5'd3,  LE = 5'd5,  LI = 5'd9;
  localparam logic [4:0] LN = 5'd14, LR = 5'd18, LS = 5'd19, LY = 5'd25, LZ = 5'd26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [9:0] col;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  scored_board_if #(.WORD_LEN(WL), .NUM_WORDS(NW), .LETTER_W(LW)) bus ();

  scored_board #(.WORD_LEN(WL), .NUM_WORDS(NW), .LETTER_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [24:0] mkw(input logic [4:0] l0, l1, l2, l3, l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [9:0] mkc(input color_t c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_row(input int r, input logic [24:0] w);
    for (int c = 0; c < WL; c++) begin
      bus.word_mask   = 7'(1 << r);
      bus.letter_mask = 5'(1 << c);
      bus.new_letter  = w[c*5 +: 5];
      tick();
    end
    bus.word_mask   = '0;
    bus.letter_mask = '0;
  endtask

  task automatic rd(input string name, input int wi, input int li, input logic [4:0] exp);
    bus.word_index   = 3'(wi);
    bus.letter_index = 3'(li);
    tick();
    chk(name, bus.letter, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.score_busy && n < 40) begin
      tick();
      n++;
    end
    if (bus.score_busy) chk("idle_timeout", bus.score_busy, 0);
  endtask

  task automatic score(input int row, input logic [9:0] exp);
    wait_idle();
    bus.score_row = 3'(row);
    bus.score_req = 1'b1;
    sb.push_back('{col: exp, cyc: cyc + 8});
    tick();
    bus.score_req = 1'b0;
    chk("busy_after_accept", bus.score_busy, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("valid_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.score_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got colors %0h expected no valid", bus.colors);
        end else begin
          e = sb.pop_front();
          chk("colors", bus.colors, e.col);
          chk("valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    bus.clear = 1'b0; bus.word_mask = '0; bus.letter_mask = '0; bus.new_letter = '0;
    bus.word_index = '0; bus.letter_index = '0; bus.score_req = 1'b0; bus.score_row = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_letter", bus.letter, 0);
    chk("rst_colors", bus.colors, 0);
    chk("rst_busy", bus.score_busy, 0);
    chk("rst_valid", bus.score_valid, 0);
    rst = 1'b0;
    tick();

    wr_row(0, mkw(LC, LR, LA, LN, LE));
    wr_row(1, mkw(LC, LR, LA, LN, LE));
    wr_row(2, mkw(LE, LE, LR, LI, LE));
    wr_row(3, mkw(LN, 5'd0, LC, 5'd0, LR));

    // Multi-row, multi-column write in one cycle.
    bus.word_mask = 7'b1100000; bus.letter_mask = 5'b00101; bus.new_letter = LZ;
    tick();
    bus.word_mask = '0; bus.letter_mask = '0;

    rd("rd_r0c0", 0, 0, LC);
    rd("rd_r2c2", 2, 2, LR);
    rd("rd_multi_r6c2", 6, 2, LZ);
    rd("rd_multi_r5c0", 5, 0, LZ);
    rd("rd_multi_r5c1", 5, 1, 5'd0);
    rd("rd_row_oob", 7, 0, 5'd0);
    rd("rd_col_oob", 0, 5, 5'd0);

    score(1, mkc(GREEN, GREEN, GREEN, GREEN, GREEN));
    drain();
    score(0, mkc(GREEN, GREEN, GREEN, GREEN, GREEN));
    drain();
    score(2, mkc(GREY, GREY, YELLOW, GREY, GREEN));
    drain();
    score(3, mkc(YELLOW, BLANK, YELLOW, BLANK, YELLOW));
    drain();
    score(7, mkc(BLANK, BLANK, BLANK, BLANK, BLANK));
    drain();

    // Overwrite the solution and re-request while busy; the in-flight result must not move.
    score(2, mkc(GREY, GREY, YELLOW, GREY, GREEN));
    bus.word_mask = 7'b1; bus.letter_mask = 5'h1f; bus.new_letter = LZ;
    bus.score_req = 1'b1; bus.score_row = 3'd1;
    tick();
    bus.score_req = 1'b0;
    bus.clear = 1'b1; bus.letter_mask = 5'b1; bus.new_letter = LY;
    tick();
    bus.clear = 1'b0; bus.word_mask = '0; bus.letter_mask = '0;
    drain();
    repeat (12) tick();
    chk("colors_held", bus.colors, mkc(GREY, GREY, YELLOW, GREY, GREEN));
    rd("clear_priority", 0, 0, 5'd0);

    wr_row(0, mkw(LA, LB, LB, LE, LY));
    wr_row(4, mkw(LB, LA, LB, LE, LS));
    score(4, mkc(YELLOW, YELLOW, GREEN, GREEN, GREY));
    drain();

    // Abort a scoring with reset, then request on the first clock after release.
    wait_idle();
    bus.score_row = 3'd4;
    bus.score_req = 1'b1;
    tick();
    bus.score_req = 1'b0;
    chk("abort_busy_accept", bus.score_busy, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.score_busy, 0);
    chk("abort_valid", bus.score_valid, 0);
    chk("abort_colors", bus.colors, 0);
    tick();
    tick();
    rst = 1'b0;
    bus.score_row = 3'd0;
    bus.score_req = 1'b1;
    sb.push_back('{col: 10'd0, cyc: cyc + 8});
    tick();
    bus.score_req = 1'b0;
    chk("first_clock_accept", bus.score_busy, 1);
    drain();
    repeat (10) tick();
    rd("rst_board_r0", 0, 0, 5'd0);
    rd("rst_board_r4", 4, 0, 5'd0);
    chk("post_rst_colors", bus.colors, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
